// File: rtl/wave_seq.sv
// wave_seq: timed waveform sample generator driving a DAC serializer.
// A programmable tick paces samples. Each sample is a start/done handshake
// with the serializer. The phase accumulator advances only after the
// conversion has completed.
//
// Handshake with the serializer: dac_start is a level request that stays
// high until dac_done is sampled low, which means the serializer has
// accepted the request. The conversion is finished when dac_done returns
// high. dac_din is held stable from the request until the conversion ends.
module wave_seq #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [1:0]          mode,
    input  logic [11:0]         step,
    input  logic                dac_done,
    output logic                dac_start,
    output logic [11:0]         dac_din,
    output logic                busy,
    output logic                overrun,
    output logic [15:0]         sample_cnt,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        REQ       = 2'd2,
        CONV      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [11:0]         acc_q, acc_d;
    logic [11:0]         din_q, din_d;
    logic                start_q, start_d;
    logic                overrun_q, overrun_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                tick;
    logic [11:0]         wave;

    // The tick fires when the counter reaches period. The >= comparison
    // recovers in a single cycle if period is lowered below the current count.
    assign tick = (state_q != IDLE) && (tick_cnt_q >= period);

    // Waveform value for the current phase. It is only captured at REQ entry.
    always_comb begin
        wave = acc_q;
        case (mode)
            2'd0:    wave = acc_q;
            2'd1:    wave = acc_q[11] ? {~acc_q[10:0], 1'b1} : {acc_q[10:0], 1'b0};
            2'd2:    wave = acc_q[11] ? 12'hFFF : 12'h000;
            default: wave = step;
        endcase
    end

    // Next-state, tick counter and datapath updates.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        acc_d      = acc_q;
        din_d      = din_q;
        start_d    = start_q;
        overrun_d  = overrun_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;

        if (state_q != IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + PERIOD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = WAIT_TICK;
                    tick_cnt_d = '0;
                end
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = REQ;
                    din_d   = wave;
                    start_d = 1'b1;
                    mode_d  = mode;
                end
            end
            REQ: begin
                // Ticks that arrive during a conversion are dropped and flagged.
                if (tick) overrun_d = 1'b1;
                if (!dac_done) begin
                    state_d = CONV;
                    start_d = 1'b0;
                end
            end
            CONV: begin
                if (tick) overrun_d = 1'b1;
                if (dac_done) begin
                    cnt_d = cnt_q + 16'd1;
                    // Constant mode holds the phase. This uses the mode latched for this sample.
                    if (mode_q != 2'd3) acc_d = acc_q + step;
                    state_d = enable ? WAIT_TICK : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            acc_q      <= '0;
            din_q      <= '0;
            start_q    <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
            mode_q     <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            acc_q      <= acc_d;
            din_q      <= din_d;
            start_q    <= start_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
        end
    end

    assign dac_start  = start_q;
    assign dac_din    = din_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign sample_cnt = cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_wave_seq.sv
// Directed bench for wave_seq: DAC responder model, start-edge scoreboard,
// linear test sequence.
module tb_wave_seq;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_CONV = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] period = 16'd0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] step = 12'd0;
    logic        dac_done = 1'b1;
    logic        dac_start;
    logic [11:0] dac_din;
    logic        busy;
    logic        overrun;
    logic [15:0] sample_cnt;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int starts = 0;
    logic [11:0] exp_q[$];
    int start_cyc[$];

    // DAC model state
    int  accept_delay = 0;
    int  accept_wait = 0;
    int  busy_left = 0;
    bit  dac_busy = 1'b0;
    logic prev_start = 1'b0;
    logic [11:0] exp_val;

    wave_seq #(.PERIOD_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .mode(mode),
        .step(step), .dac_done(dac_done), .dac_start(dac_start), .dac_din(dac_din),
        .busy(busy), .overrun(overrun), .sample_cnt(sample_cnt), .state_dbg(state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // DAC serializer model: it accepts a start after accept_delay cycles and then holds done low for 17 cycles.
    always @(negedge clk) begin
        if (rst) begin
            dac_done    = 1'b1;
            dac_busy    = 1'b0;
            accept_wait = 0;
            busy_left   = 0;
        end else if (!dac_busy) begin
            if (dac_start) begin
                if (accept_wait < accept_delay) begin
                    accept_wait++;
                end else begin
                    dac_done    = 1'b0;
                    dac_busy    = 1'b1;
                    busy_left   = 17;
                    accept_wait = 0;
                end
            end else begin
                accept_wait = 0;
            end
        end else begin
            busy_left--;
            if (busy_left == 0) begin
                dac_done = 1'b1;
                dac_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: each rising dac_start must carry the next expected sample.
    always @(negedge clk) begin
        if (dac_start && !prev_start) begin
            start_cyc.push_back(cyc);
            starts++;
            check("start_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_val = exp_q.pop_front();
                check("dac_din", 32'(dac_din), 32'(exp_val));
            end
        end
        prev_start = dac_start;
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (sample_cnt != 16'(target) && n < budget) begin
            tick_clk();
            n++;
        end
        check(tag, 32'(sample_cnt), 32'(target));
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (state_dbg != st && n < budget) begin
            tick_clk();
            n++;
        end
        check(tag, 32'(state_dbg), 32'(st));
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst = 1'b1;
        tick_clk();
        tick_clk();
        rst = 1'b0;
        exp_q.delete();
        start_cyc.delete();
        starts = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_dac_start", 32'(dac_start), 0);
        check("rst_dac_din", 32'(dac_din), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_sample_cnt", 32'(sample_cnt), 0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));

        // Saw: step 1024, period 99
        mode = 2'd0; step = 12'd1024; period = 16'd99;
        exp_q.push_back(12'd0);    exp_q.push_back(12'd1024);
        exp_q.push_back(12'd2048); exp_q.push_back(12'd3072);
        exp_q.push_back(12'd0);
        enable = 1'b1;
        wait_cnt(5, 1000, "saw_cnt");
        check("saw_starts", 32'(start_cyc.size()), 5);
        for (int i = 1; i < start_cyc.size(); i++)
            check("saw_spacing", 32'(start_cyc[i] - start_cyc[i-1]), 100);
        check("saw_overrun", 32'(overrun), 0);
        enable = 1'b0;
        wait_state(S_IDLE, 200, "saw_idle");

        // Triangle: step 512, nine samples cover one full period
        do_reset();
        mode = 2'd1; step = 12'd512; period = 16'd29;
        exp_q.push_back(12'd0);    exp_q.push_back(12'd1024);
        exp_q.push_back(12'd2048); exp_q.push_back(12'd3072);
        exp_q.push_back(12'd4095); exp_q.push_back(12'd3071);
        exp_q.push_back(12'd2047); exp_q.push_back(12'd1023);
        exp_q.push_back(12'd0);
        enable = 1'b1;
        wait_cnt(9, 1000, "tri_cnt");
        check("tri_overrun", 32'(overrun), 0);
        enable = 1'b0;
        wait_state(S_IDLE, 200, "tri_idle");
        // acc (512) and sample_cnt survive enable cycling
        exp_q.push_back(12'd1024);
        enable = 1'b1;
        wait_cnt(10, 200, "tri_resume_cnt");
        enable = 1'b0;
        wait_state(S_IDLE, 200, "tri_resume_idle");

        // Constant mode outputs step and leaves the phase (1024) untouched
        mode = 2'd3; step = 12'd777;
        exp_q.push_back(12'd777); exp_q.push_back(12'd777);
        enable = 1'b1;
        wait_cnt(12, 200, "const_cnt");
        enable = 1'b0;
        wait_state(S_IDLE, 200, "const_idle");
        mode = 2'd0; step = 12'd100;
        exp_q.push_back(12'd1024);
        enable = 1'b1;
        wait_cnt(13, 200, "const_hold_acc");
        enable = 1'b0;
        wait_state(S_IDLE, 200, "const_idle2");

        // Overrun: the tick period is shorter than a conversion
        do_reset();
        mode = 2'd0; step = 12'd1; period = 16'd5;
        exp_q.push_back(12'd0); exp_q.push_back(12'd1); exp_q.push_back(12'd2);
        enable = 1'b1;
        wait_cnt(1, 200, "ovr_first");
        check("ovr_set", 32'(overrun), 1);
        wait_cnt(3, 300, "ovr_cnt");
        enable = 1'b0;
        wait_state(S_IDLE, 200, "ovr_idle");
        check("ovr_sticky", 32'(overrun), 1);
        check("ovr_cnt_per_conv", 32'(sample_cnt), 32'(starts));

        // Handshake: done stays high for 10 cycles after the start
        do_reset();
        accept_delay = 9;
        mode = 2'd0; step = 12'd7; period = 16'd99;
        exp_q.push_back(12'd0);
        enable = 1'b1;
        wait_state(S_REQ, 300, "hs_req");
        for (int i = 0; i < 10; i++) begin
            check("hs_start_held", 32'(dac_start), 1);
            check("hs_din_stable", 32'(dac_din), 0);
            tick_clk();
        end
        check("hs_conv_state", 32'(state_dbg), 32'(S_CONV));
        check("hs_start_drop", 32'(dac_start), 0);
        check("hs_din_conv", 32'(dac_din), 0);
        wait_cnt(1, 200, "hs_cnt");
        enable = 1'b0;
        wait_state(S_IDLE, 200, "hs_idle");
        accept_delay = 0;

        // Control: dropping enable in CONV finishes the sample and then idles
        do_reset();
        mode = 2'd0; step = 12'd300; period = 16'd49;
        exp_q.push_back(12'd0);
        enable = 1'b1;
        wait_state(S_CONV, 300, "ctl_conv");
        enable = 1'b0;
        wait_state(S_IDLE, 200, "ctl_idle");
        check("ctl_busy", 32'(busy), 0);
        check("ctl_cnt", 32'(sample_cnt), 1);
        exp_q.push_back(12'd300);
        enable = 1'b1;
        wait_cnt(2, 300, "ctl_acc_kept");
        // Reset while the DUT waits in REQ
        accept_delay = 5;
        exp_q.push_back(12'd600);
        wait_state(S_REQ, 300, "ctl_req");
        rst = 1'b1;
        tick_clk();
        check("ctl_rst_start", 32'(dac_start), 0);
        check("ctl_rst_din", 32'(dac_din), 0);
        check("ctl_rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("ctl_rst_cnt", 32'(sample_cnt), 0);
        accept_delay = 0;
        exp_q.push_back(12'd0);
        rst = 1'b0;
        wait_cnt(1, 300, "ctl_acc_cleared");
        enable = 1'b0;
        wait_state(S_IDLE, 200, "ctl_final_idle");

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_seq.md
WAVE_SEQ -- requirements
Module: wave_seq

Interface
REQ-001 The block SHALL have parameter PERIOD_W, default 16: width of the sample-period register.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port enable, input, 1: run request; high = generate samples.
REQ-005 Port period, input, PERIOD_W: sample interval minus one, in clk cycles; sampled at each tick.
REQ-006 Port mode, input, 2: waveform select; 0 saw, 1 triangle, 2 square, 3 constant.
REQ-007 Port step, input, 12: phase increment per sample (modes 0-2); output level (mode 3).
REQ-008 Port dac_done, input, 1: idle/done flag from the downstream DAC serializer; high = idle.
REQ-009 Port dac_start, output, 1: conversion request to the DAC serializer.
REQ-010 Port dac_din, output, 12: sample code presented to the DAC serializer.
REQ-011 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-012 Port overrun, output, 1: sticky flag; a tick arrived while a conversion was still in flight.
REQ-013 Port sample_cnt, output, 16: number of completed conversions, wraps 65535 -> 0.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_TICK, REQ and CONV.
REQ-015 IDLE -> WAIT_TICK when enable=1; tick counter is cleared on this transition.
REQ-016 Tick counter SHALL count 0..period while not in IDLE and assert tick for one cycle when it equals period, then return to 0; period=0 SHALL give a tick every cycle.
REQ-017 WAIT_TICK -> REQ on tick with enable=1; WAIT_TICK -> IDLE when enable=0.
REQ-018 On entry to REQ, dac_din SHALL load the waveform value of the current phase acc[11:0] and dac_start SHALL go high.
REQ-019 In REQ, dac_start SHALL stay high until dac_done is sampled low; the FSM then moves to CONV and drops dac_start in the same edge.
REQ-020 In CONV, the FSM SHALL wait for dac_done=1, then increment sample_cnt, advance acc by step (mod 4096), and go to WAIT_TICK if enable=1, else IDLE.
REQ-021 dac_din SHALL remain stable from REQ entry until CONV exit.
REQ-022 A tick in REQ or CONV SHALL set overrun and is discarded; the conversion in flight completes unaffected.
REQ-023 enable falling in REQ or CONV SHALL NOT abort; the conversion completes first.
REQ-024 Waveform, with t = acc[10:0]: mode 0 out = acc; mode 1 out = {t,0} if acc[11]=0, else {~t,1}; mode 2 out = 4095 if acc[11]=1, else 0; mode 3 out = step, and acc is not advanced.
REQ-025 mode and step SHALL be sampled only at REQ entry (mode/value) and CONV exit (increment); changes mid-conversion take effect on the next sample.
REQ-026 acc and sample_cnt SHALL be held, not cleared, across enable cycling.
REQ-027 overrun SHALL clear only on rst.

Reset
REQ-028 On rst=1 at a rising edge, the block SHALL go to IDLE with acc=0, tick counter=0, dac_start=0, dac_din=0, busy=0, overrun=0 and sample_cnt=0.
REQ-029 rst mid-conversion SHALL drop dac_start immediately; the block SHALL then ignore dac_done until enable and a new tick start the next sample.

Verification
REQ-030 The bench SHALL model the DAC as dac_done low 17 cycles after start acceptance.
REQ-031 Saw: mode=0, step=1024, period=99 -> dac_din sequence 0, 1024, 2048, 3072, 0; starts 100 cycles apart; overrun=0.
REQ-032 Triangle: mode=1, step=512 -> dac_din 0, 1024, 2048, 3072, 4095, 3071, 2047, 1023, then 0 again.
REQ-033 Overrun: period=5 with the 17-cycle DAC -> overrun=1 after the first sample, samples still complete, and sample_cnt increments once per conversion.
REQ-034 Handshake: hold dac_done high for 10 cycles after start -> dac_start stays high for all 10 cycles, dac_din is unchanged, and the FSM enters CONV on the first cycle dac_done=0.
REQ-035 Control: drop enable during CONV -> the conversion finishes, the FSM goes to IDLE with busy=0, and acc is retained; asserting rst mid-REQ gives dac_start=0 and acc=0 on the next cycle.
